divider_scheduler: RTL and testbench

Round-robin scheduler that shares one `sequential_divider` instance among `NUM_CH` synthesizer channels that each need a count scaled by a per-channel divisor. It accepts operand requests, issues one division at a time to the divider, waits for its `done` pulse, and returns the 8-bit quotient tagged with the requesting channel. It also bypasses zero divisors, which the divider never completes, and optionally recovers from a hung divider.

---
 rtl/divider_scheduler_if.sv | 33 +++
 rtl/divider_scheduler.sv | 166 ++++++++++++++++
 tb/tb_divider_scheduler.sv | 329 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/divider_scheduler_if.sv
// Request/result/divider bundle for divider_scheduler; master is the scheduler's view,
// slave is the view of the channels and the shared divider.
interface divider_scheduler_if #(
   parameter int NUM_CH = 4
);
   logic [NUM_CH-1:0]    req;
   logic [NUM_CH*24-1:0] req_count;
   logic [NUM_CH*24-1:0] req_divisor;
   logic [NUM_CH-1:0]    req_ack;
   logic                 res_valid;
   logic [2:0]           res_ch;
   logic [7:0]           res_data;
   logic                 res_err;
   logic                 busy;
   logic                 div_sample_now;
   logic [23:0]          div_count;
   logic [23:0]          div_divisor;
   logic [7:0]           div_scaled_count;
   logic                 div_done;
   logic                 div_abort;

   modport master (
      input  req, req_count, req_divisor, div_scaled_count, div_done,
      output req_ack, res_valid, res_ch, res_data, res_err, busy,
             div_sample_now, div_count, div_divisor, div_abort
   );

   modport slave (
      output req, req_count, req_divisor, div_scaled_count, div_done,
      input  req_ack, res_valid, res_ch, res_data, res_err, busy,
             div_sample_now, div_count, div_divisor, div_abort
   );
endinterface

// File: rtl/divider_scheduler.sv
// Round-robin arbiter sharing one sequential divider among NUM_CH channels.
// Define DIV_SCHED_TIMEOUT_EN to enable the WAIT watchdog and div_abort.
module divider_scheduler #(
   parameter int NUM_CH  = 4,
   parameter int TIMEOUT = 128
) (
   input logic                 clk,
   input logic                 rst,
   divider_scheduler_if.master bus
);
   typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_DELIVER, S_ERR} state_t;

   state_t            state_q, state_d;
   logic [2:0]        last_q;
   logic [2:0]        ch_q;
   logic [23:0]       count_q;
   logic [23:0]       divisor_q;
   logic [NUM_CH-1:0] req_ack_q;
   logic              res_valid_q;
   logic              res_err_q;
   logic [2:0]        res_ch_q;
   logic [7:0]        res_data_q;

   logic [7:0]        req_pad;
   logic [23:0]       cnt_ch [8];
   logic [23:0]       dvs_ch [8];
   logic              grant_valid;
   logic [2:0]        grant_ch;
   logic [2:0]        idx;
   logic              grant_fire;

   // Pad to eight lanes so a 3-bit channel index never selects outside the arrays.
   for (genvar gi = 0; gi < 8; gi++) begin : g_lane
      if (gi < NUM_CH) begin : g_used
         assign req_pad[gi] = bus.req[gi];
         assign cnt_ch[gi]  = bus.req_count[24*gi +: 24];
         assign dvs_ch[gi]  = bus.req_divisor[24*gi +: 24];
      end else begin : g_unused
         assign req_pad[gi] = 1'b0;
         assign cnt_ch[gi]  = 24'd0;
         assign dvs_ch[gi]  = 24'd0;
      end
   end

   always_comb begin
      grant_valid = 1'b0;
      grant_ch    = '0;
      idx         = '0;
      for (int k = 1; k <= NUM_CH; k++) begin
         idx = 3'((int'(last_q) + k) % NUM_CH);
         if (!grant_valid && req_pad[idx]) begin
            grant_valid = 1'b1;
            grant_ch    = idx;
         end
      end
   end

   assign grant_fire = (state_q == S_IDLE) && grant_valid;

`ifdef DIV_SCHED_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT + 1);
   logic [TW-1:0] timer_q;
   logic          timeout_hit;
   logic          div_abort_q;
`endif

   always_comb begin
      state_d = state_q;
`ifdef DIV_SCHED_TIMEOUT_EN
      timeout_hit = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (grant_valid) begin
               state_d = (dvs_ch[grant_ch] == 24'd0) ? S_ERR : S_ISSUE;
            end
         end
         S_ISSUE: state_d = S_WAIT;
         S_WAIT: begin
            // A completion in the same cycle as the watchdog expiry takes priority.
            if (bus.div_done) begin
               state_d = S_DELIVER;
            end
`ifdef DIV_SCHED_TIMEOUT_EN
            else if (timer_q == TW'(TIMEOUT - 1)) begin
               timeout_hit = 1'b1;
               state_d     = S_ERR;
            end
`endif
         end
         S_DELIVER: state_d = S_IDLE;
         S_ERR:     state_d = S_IDLE;
         default:   state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         last_q      <= 3'(NUM_CH - 1);
         ch_q        <= '0;
         count_q     <= '0;
         divisor_q   <= '0;
         req_ack_q   <= '0;
         res_valid_q <= 1'b0;
         res_err_q   <= 1'b0;
         res_ch_q    <= '0;
         res_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         req_ack_q   <= '0;
         res_valid_q <= 1'b0;
         res_err_q   <= 1'b0;
         res_ch_q    <= '0;
         res_data_q  <= '0;
         if (grant_fire) begin
            req_ack_q <= NUM_CH'(1) << grant_ch;
            last_q    <= grant_ch;
            ch_q      <= grant_ch;
            count_q   <= cnt_ch[grant_ch];
            divisor_q <= dvs_ch[grant_ch];
         end
         // Normal results appear with DELIVER; error results one cycle after ERR.
         if (state_q == S_WAIT && bus.div_done) begin
            res_valid_q <= 1'b1;
            res_ch_q    <= ch_q;
            res_data_q  <= bus.div_scaled_count;
         end
         if (state_q == S_ERR) begin
            res_valid_q <= 1'b1;
            res_err_q   <= 1'b1;
            res_ch_q    <= ch_q;
            res_data_q  <= 8'hFF;
         end
      end
   end

`ifdef DIV_SCHED_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         timer_q     <= '0;
         div_abort_q <= 1'b0;
      end else begin
         div_abort_q <= timeout_hit;
         if (state_q == S_ISSUE) begin
            timer_q <= '0;
         end else if (state_q == S_WAIT) begin
            timer_q <= timer_q + 1'b1;
         end
      end
   end
   assign bus.div_abort = div_abort_q;
`else
   assign bus.div_abort = 1'b0;
`endif

   assign bus.req_ack        = req_ack_q;
   assign bus.res_valid      = res_valid_q;
   assign bus.res_err        = res_err_q;
   assign bus.res_ch         = res_ch_q;
   assign bus.res_data       = res_data_q;
   assign bus.busy           = (state_q != S_IDLE);
   assign bus.div_sample_now = (state_q == S_ISSUE);
   assign bus.div_count      = count_q;
   assign bus.div_divisor    = divisor_q;
endmodule

// File: tb/tb_divider_scheduler.sv
// Directed bench for divider_scheduler: a transaction-level model checks every cycle,
// literal expectations pin grant order, quotients and latencies.
module tb_divider_scheduler;
   localparam int NUM_CH  = 4;
   localparam int TIMEOUT = 128;
   localparam int DIV_LAT = 4;

   typedef struct {int ch; int data; int err; int cyc;} res_t;

   logic clk = 1'b0;
   logic rst = 1'b1;

   divider_scheduler_if #(.NUM_CH(NUM_CH)) bus ();

   divider_scheduler #(.NUM_CH(NUM_CH), .TIMEOUT(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_pass   = 0;

   task automatic check(string name, longint act, longint exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   // ---------------- divider model ----------------
   logic       hang = 1'b0;
   logic       model_done = 1'b0;
   logic       stray_done = 1'b0;
   logic [7:0] model_q = 8'd0;
   int         dcnt = 0;

   assign bus.div_done         = model_done | stray_done;
   assign bus.div_scaled_count = model_q;

   always @(posedge clk) begin
      #1;
      model_done = 1'b0;
      if (dcnt != 0) begin
         dcnt--;
         if (dcnt == 0) model_done = 1'b1;
      end
      if (bus.div_sample_now && !hang && bus.div_divisor != 0) begin
         dcnt    = DIV_LAT;
         model_q = 8'(bus.div_count / bus.div_divisor);
      end
   end

   // ---------------- reference model + per-cycle compare ----------------
   int   ack_log[$];
   int   ack_cyc_log[$];
   int   abort_cyc_log[$];
   res_t res_log[$];
   int   sample_count = 0;
   bit   auto_drop = 1'b1;

   int   cyc = 0;
   logic rst_d = 1'b1;
   logic [NUM_CH-1:0]    prev_req = '0;
   logic [NUM_CH*24-1:0] prev_cnt = '0;
   logic [NUM_CH*24-1:0] prev_div = '0;
   int   m_last = NUM_CH - 1;
   bit   pend = 0, issued = 0, done_prev = 0, abort_prev = 0;
   int   ack_cyc = 0, sample_cyc = 0;
   int   e_ch = 0, e_data = 0, e_err = 0;
   bit   e_zero = 0, e_hang = 0;

   function automatic int rr_pick(logic [NUM_CH-1:0] r, int last);
      for (int k = 1; k <= NUM_CH; k++) begin
         int c = (last + k) % NUM_CH;
         if (r[c]) return c;
      end
      return -1;
   endfunction

   always @(negedge clk) begin
      int      p, a_idx;
      bit      exp_valid, exp_sample, exp_abort, ack_now;
      longint  cnt, dv;
      cyc++;
      ack_now = 1'b0;
      if (rst_d) begin
         check("reset_ctl", {bus.req_ack, bus.res_valid, bus.res_ch, bus.res_data, bus.res_err,
                             bus.busy, bus.div_sample_now, bus.div_abort}, 0);
         check("reset_div_count", bus.div_count, 0);
         check("reset_div_divisor", bus.div_divisor, 0);
         m_last = NUM_CH - 1; pend = 0; issued = 0; done_prev = 0; abort_prev = 0;
      end else begin
         // results
         exp_valid = pend && ((e_zero && cyc == ack_cyc + 1) || done_prev || abort_prev);
         check("res_valid", bus.res_valid, exp_valid);
         if (bus.res_valid) res_log.push_back('{int'(bus.res_ch), int'(bus.res_data), int'(bus.res_err), cyc});
         if (bus.res_valid && exp_valid) begin
            check("res_ch", bus.res_ch, e_ch);
            check("res_data", bus.res_data, e_data);
            check("res_err", bus.res_err, e_err);
            pend = 0;
         end
         // grants
         p = rr_pick(prev_req, m_last);
         if (bus.req_ack != '0) begin
            check("ack_grant", bus.req_ack, (p < 0) ? 0 : (longint'(1) << p));
            check("ack_one_outstanding", pend, 0);
            a_idx = -1;
            for (int i = 0; i < NUM_CH; i++) if (bus.req_ack[i] && a_idx < 0) a_idx = i;
            ack_log.push_back(a_idx);
            ack_cyc_log.push_back(cyc);
            if (p >= 0) begin
               ack_now = 1'b1;
               m_last = p; pend = 1; issued = 0; ack_cyc = cyc; e_ch = p;
               cnt = prev_cnt[24*p +: 24];
               dv  = prev_div[24*p +: 24];
               e_zero = (dv == 0);
               e_hang = hang;
               if (e_zero || hang) begin e_data = 255; e_err = 1; end
               else begin e_data = int'((cnt / dv) % 256); e_err = 0; end
            end
         end
         exp_sample = ack_now && !e_zero;
         check("div_sample_now", bus.div_sample_now, exp_sample);
         if (bus.div_sample_now) begin
            issued = 1; sample_cyc = cyc; sample_count++;
         end
`ifdef DIV_SCHED_TIMEOUT_EN
         exp_abort = pend && issued && e_hang && (cyc == sample_cyc + 1 + TIMEOUT);
`else
         exp_abort = 1'b0;
`endif
         check("div_abort", bus.div_abort, exp_abort);
         if (bus.div_abort) abort_cyc_log.push_back(cyc);
         abort_prev = bus.div_abort && pend;
         done_prev  = bus.div_done && pend && issued && !e_hang;
      end
      if (auto_drop) bus.req = bus.req & ~bus.req_ack;
      prev_req = bus.req;
      prev_cnt = bus.req_count;
      prev_div = bus.req_divisor;
      rst_d    = rst;
   end

   // ---------------- stimulus helpers ----------------
   task automatic set_ch(int ch, int count, int divisor);
      bus.req_count[24*ch +: 24]   = 24'(count);
      bus.req_divisor[24*ch +: 24] = 24'(divisor);
   endtask

   task automatic wait_acks(int n, int budget);
      int b = 0;
      while (ack_log.size() < n && b < budget) begin
         @(posedge clk);
         b++;
      end
      #1;
      check("wait_acks", ack_log.size(), n);
   endtask

   task automatic wait_quiet(int budget);
      int b = 0;
      while ((pend || bus.busy) && b < budget) begin
         @(posedge clk);
         b++;
      end
      repeat (2) @(posedge clk);
      #1;
      check("wait_quiet", pend || bus.busy, 0);
   endtask

   task automatic clear_logs();
      ack_log.delete();
      ack_cyc_log.delete();
      abort_cyc_log.delete();
      res_log.delete();
   endtask

   function automatic int ack_at(int i);
      return (i < ack_log.size()) ? ack_log[i] : -1;
   endfunction

   function automatic int ackc_at(int i);
      return (i < ack_cyc_log.size()) ? ack_cyc_log[i] : -1000;
   endfunction

   function automatic res_t res_at(int i);
      res_t r = '{-1, -1, -1, -1000};
      if (i < res_log.size()) r = res_log[i];
      return r;
   endfunction

   task automatic pulse_reset();
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
   endtask

   initial begin
      #300000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   // ---------------- directed tests ----------------
   initial begin
      res_t r;
      int   s0;
      bus.req = '0; bus.req_count = '0; bus.req_divisor = '0;
      repeat (3) @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;

      // single request: ch1 1000/4
      clear_logs(); s0 = sample_count;
      set_ch(1, 1000, 4); bus.req = 4'b0010;
      wait_acks(1, 20); wait_quiet(50);
      r = res_at(0);
      check("single_ack_ch", ack_at(0), 1);
      check("single_res_ch", r.ch, 1);
      check("single_res_data", r.data, 8'hFA);
      check("single_res_err", r.err, 0);
      check("single_samples", sample_count - s0, 1);
      check("single_latency", r.cyc - ackc_at(0), 5);
      $display("single: ack ch%0d res ch%0d data %0h err %0d", ack_at(0), r.ch, r.data, r.err);

      // round robin with all requests held from reset
      rst = 1'b1; auto_drop = 1'b0; clear_logs();
      for (int i = 0; i < NUM_CH; i++) set_ch(i, (i + 1) * 300, i + 2);
      bus.req = 4'b1111;
      repeat (2) @(posedge clk); #1;
      rst = 1'b0;
      wait_acks(5, 200);
      bus.req = 4'b1001;
      wait_acks(6, 100);
      bus.req = '0; auto_drop = 1'b1;
      wait_quiet(60);
      check("rr_g0", ack_at(0), 0);
      check("rr_g1", ack_at(1), 1);
      check("rr_g2", ack_at(2), 2);
      check("rr_g3", ack_at(3), 3);
      check("rr_g4", ack_at(4), 0);
      check("rr_g5", ack_at(5), 3);
      check("rr_ch2_quot", res_at(2).data, 225);
      $display("rr: grants %0d %0d %0d %0d %0d %0d", ack_at(0), ack_at(1), ack_at(2), ack_at(3), ack_at(4), ack_at(5));

      // zero divisor on ch2
      clear_logs(); s0 = sample_count;
      set_ch(2, 77, 0); bus.req = 4'b0100;
      wait_acks(1, 20); wait_quiet(20);
      r = res_at(0);
      check("zero_ack_ch", ack_at(0), 2);
      check("zero_res", {r.ch[2:0], r.data[7:0], r.err[0]}, {3'd2, 8'hFF, 1'b1});
      check("zero_latency", r.cyc - ackc_at(0), 1);
      check("zero_no_sample", sample_count - s0, 0);
      $display("zero: ack ch%0d res data %0h err %0d", ack_at(0), r.data, r.err);

      // truncation of quotient to 8 bits
      clear_logs();
      set_ch(0, 24'h0001F4, 1); set_ch(3, 1000, 2); bus.req = 4'b1001;
      wait_acks(2, 40); wait_quiet(40);
      check("trunc_500_1", res_at(0).data, 8'hF4);
      check("trunc_1000_2", res_at(1).data, 8'hF4);
      $display("trunc: %0h %0h", res_at(0).data, res_at(1).data);

      // withdrawn request is not served
      clear_logs();
      set_ch(1, 600, 3); bus.req = 4'b0010;
      wait_acks(1, 20);
      set_ch(3, 50, 5); bus.req[3] = 1'b1;
      repeat (2) @(posedge clk); #1;
      bus.req[3] = 1'b0;
      wait_quiet(40);
      check("withdraw_acks", ack_log.size(), 1);
      check("withdraw_res", res_at(0).data, 200);
      $display("withdraw: acks %0d", ack_log.size());

      // reset while waiting, then a stray done
      clear_logs();
      set_ch(1, 300, 3); hang = 1'b1; bus.req = 4'b0010;
      wait_acks(1, 20);
      repeat (3) @(posedge clk); #1;
      pulse_reset();
      hang = 1'b0; stray_done = 1'b1;
      @(posedge clk); #1;
      stray_done = 1'b0;
      repeat (8) @(posedge clk); #1;
      check("rstwait_busy", bus.busy, 0);
      check("rstwait_no_res", res_log.size(), 0);
      set_ch(0, 90, 9); set_ch(2, 80, 8); bus.req = 4'b0101;
      wait_acks(3, 40); wait_quiet(40);
      check("rstwait_next_ch0", ack_at(1), 0);
      check("rstwait_then_ch2", ack_at(2), 2);
      $display("rstwait: next grants %0d %0d", ack_at(1), ack_at(2));

      // divider never completes
      clear_logs();
      set_ch(3, 1234, 5); hang = 1'b1; bus.req = 4'b1000;
      wait_acks(1, 20);
`ifdef DIV_SCHED_TIMEOUT_EN
      begin
         int b = 0;
         while (res_log.size() < 1 && b < 400) begin @(posedge clk); b++; end
         #1;
      end
      r = res_at(0);
      check("tmo_abort_count", abort_cyc_log.size(), 1);
      check("tmo_abort_latency", (abort_cyc_log.size() > 0) ? abort_cyc_log[0] - ackc_at(0) : -1, 129);
      check("tmo_res_after_abort", (abort_cyc_log.size() > 0) ? r.cyc - abort_cyc_log[0] : -1, 1);
      check("tmo_res", {r.ch[2:0], r.data[7:0], r.err[0]}, {3'd3, 8'hFF, 1'b1});
      $display("timeout: abort after %0d cycles, res err %0d", (abort_cyc_log.size() > 0) ? abort_cyc_log[0] - ackc_at(0) : -1, r.err);
      wait_quiet(20);
`else
      repeat (300) @(posedge clk); #1;
      check("hang_busy", bus.busy, 1);
      check("hang_no_res", res_log.size(), 0);
      check("hang_no_abort", abort_cyc_log.size(), 0);
      $display("hang: busy %0d after 300 cycles", bus.busy);
      pulse_reset();
`endif
      hang = 1'b0;
      repeat (3) @(posedge clk); #1;

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
